register_file_mp: RTL and testbench

//  Parametrised multi-read-port CPU register file; successor to the 2R/1W integer register file.

---
 rtl/register_file_mp.sv | 194 +++++++++++++++++++
 tb/tb_register_file_mp.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Parametrised multi-read-port CPU register file. One write port (from
// writeback), NUM_RD independent read ports (from decode), optional hardwired
// zero register, optional write-to-read bypass, a read enable that freezes all
// read outputs, and a hardware clear sweep that zeroes the storage array
// after reset and on request.
//
// Ports
//   i_clk     in   1            clock, rising edge
//   i_rst_n   in   1            asynchronous active-low reset
//   i_clear   in   1            request a full clear sweep (pulse)
//   o_ready   out  1            1 = normal operation, 0 = clear sweep running
//   i_we      in   1            write enable
//   i_waddr   in   AW           write address
//   i_wdata   in   XLEN         write data
//   i_re      in   1            read enable, 0 = every o_rdata port holds
//   i_raddr   in   NUM_RD*AW    read addresses, port k at [k*AW +: AW]
//   o_rdata   out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
//
// Timing
//   Reads have one cycle of latency. The storage array has no reset of its
//   own; after reset release the sweep writes zero into one entry per cycle,
//   so o_ready rises exactly DEPTH cycles after reset is released.
// ---------------------------------------------------------------------------
module register_file_mp #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_clear,
   output logic                     o_ready,
   input  logic                     i_we,
   input  logic [AW-1:0]            i_waddr,
   input  logic [XLEN-1:0]          i_wdata,
   input  logic                     i_re,
   input  logic [NUM_RD*AW-1:0]     i_raddr,
   output logic [NUM_RD*XLEN-1:0]   o_rdata
);

   // ------------------------------------------------------------------------
   // Sweep FSM encoding
   // ------------------------------------------------------------------------
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [0:0]       state_reg;
   logic [0:0]       state_next;
   logic [AW-1:0]    cnt_reg;
   logic [AW-1:0]    cnt_next;
   logic             ready;

   // ------------------------------------------------------------------------
   // Storage and its single write port
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  mem [DEPTH];

   logic             wr_discard;
   logic             user_wr;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [XLEN-1:0]  mem_wdata;

   assign ready = (state_reg == ST_READY);

   // ------------------------------------------------------------------------
   // Next-state logic
   //
   // CLEAR walks cnt from 0 to DEPTH-1, one entry per cycle. A clear request
   // that arrives while sweeping restarts the walk from entry 0 so that the
   // whole array is guaranteed to be zero when READY is reached, whatever
   // happened earlier in the sweep.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_CLEAR: begin
            if (i_clear) begin
               cnt_next = '0;
            end else if (cnt_reg == LAST_IDX) begin
               state_next = ST_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_READY: begin
            if (i_clear) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign o_ready = ready;

   // ------------------------------------------------------------------------
   // Write port arbitration
   //
   // The sweep and the writeback path share one physical write port: while
   // sweeping, the sweep owns it and the caller's write is ignored. A write
   // in the same cycle as a clear request from READY still lands, and is then
   // overwritten by the sweep that follows.
   // ------------------------------------------------------------------------
   assign wr_discard = (ZERO_REG != 0) && (i_waddr == '0);
   assign user_wr    = ready && i_we && !wr_discard;

   assign mem_we    = !ready || user_wr;
   assign mem_waddr = ready ? i_waddr : cnt_reg;
   assign mem_wdata = ready ? i_wdata : '0;

   // No reset on the array so that it maps onto block/distributed RAM.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports
   //
   // Each port is an independent registered read. The array read returns the
   // value from before the current edge; the bypass mux substitutes the
   // incoming write data when a live (non-discarded) write targets the same
   // entry. The zero register takes priority over the bypass so that r0
   // cannot leak a discarded write.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [AW-1:0]   raddr;
         logic            zero_hit;
         logic            bypass_hit;
         logic [XLEN-1:0] rd_sel;
         logic [XLEN-1:0] rdata_reg;

         assign raddr      = i_raddr[gi*AW +: AW];
         assign zero_hit   = (ZERO_REG != 0) && (raddr == '0);
         assign bypass_hit = (BYPASS != 0) && i_we && !wr_discard
                             && (i_waddr == raddr);

         always_comb begin
            rd_sel = mem[raddr];
            if (zero_hit) begin
               rd_sel = '0;
            end else if (bypass_hit) begin
               rd_sel = i_wdata;
            end
         end

         // The output register is cleared while sweeping, so after the sweep
         // ends a port that is not re-enabled presents zero, matching the
         // freshly cleared array.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               rdata_reg <= '0;
            end else if (!ready) begin
               rdata_reg <= '0;
            end else if (i_re) begin
               rdata_reg <= rd_sel;
            end
         end

         // Masking with ready forces zero from the very first cycle of a
         // sweep, rather than one cycle later through the register.
         assign o_rdata[gi*XLEN +: XLEN] = ready ? rdata_reg : '0;
      end
   endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
//
// Directed bench for register_file_mp. Two instances share every input:
//   dut     default parameters (ZERO_REG=1, BYPASS=1)
//   dut_nb  ZERO_REG=0, BYPASS=0
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re;
   logic [9:0]  raddr;
   logic        ready;
   logic        ready_nb;
   logic [63:0] rdata;
   logic [63:0] rdata_nb;

   logic [31:0] rd0, rd1, nb0, nb1;
   assign rd0 = rdata[31:0];
   assign rd1 = rdata[63:32];
   assign nb0 = rdata_nb[31:0];
   assign nb1 = rdata_nb[63:32];

   int vectors = 0;
   int fails   = 0;

   register_file_mp dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear),
      .o_ready (ready),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_re    (re),
      .i_raddr (raddr),
      .o_rdata (rdata)
   );

   register_file_mp #(
      .ZERO_REG (0),
      .BYPASS   (0)
   ) dut_nb (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear),
      .o_ready (ready_nb),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_re    (re),
      .i_raddr (raddr),
      .o_rdata (rdata_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re = 1'b0; raddr = '0;
      repeat (3) tick();
      vectors++;
      if (ready !== 1'b0 || ready_nb !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready got %b/%b exp 0/0", ready, ready_nb);
      end
      vectors++;
      if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
         fails++;
         $display("FAIL reset_rdata got %h/%h exp 0", rdata, rdata_nb);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         tick();
         vectors++;
         if (ready !== (i == 32) || ready_nb !== (i == 32)) begin
            fails++;
            $display("FAIL sweep_ready cycle %0d got %b/%b exp %b",
                     i, ready, ready_nb, (i == 32));
         end
      end
      re = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         tick();
         vectors++;
         if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
            fails++;
            $display("FAIL init_read r%0d got %h/%h exp 0", a, rdata, rdata_nb);
         end
      end
      re = 1'b0;
      $display("test_reset done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_write_read();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re = 1'b0;
      tick();
      we = 1'b0; re = 1'b1; raddr = {5'd5, 5'd5};
      tick();
      vectors++;
      if (rd0 !== 32'hDEADBEEF || rd1 !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL wr_rd_r5 got %h/%h exp deadbeef", rd0, rd1);
      end
      vectors++;
      if (nb0 !== 32'hDEADBEEF || nb1 !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL wr_rd_r5_nb got %h/%h exp deadbeef", nb0, nb1);
      end
      $display("test_write_read done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_bypass();
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; re = 1'b1;
      raddr = {5'd7, 5'd7};
      tick();
      vectors++;
      if (rd0 !== 32'h12345678 || rd1 !== 32'h12345678) begin
         fails++;
         $display("FAIL bypass_on got %h/%h exp 12345678", rd0, rd1);
      end
      vectors++;
      if (nb0 !== 32'h0 || nb1 !== 32'h0) begin
         fails++;
         $display("FAIL bypass_off got %h/%h exp 0", nb0, nb1);
      end
      we = 1'b0;
      tick();
      vectors++;
      if (nb0 !== 32'h12345678 || rd0 !== 32'h12345678) begin
         fails++;
         $display("FAIL bypass_later got %h/%h exp 12345678", nb0, rd0);
      end
      $display("test_bypass done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_zero_reg();
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re = 1'b1;
      raddr = {5'd5, 5'd0};
      tick();
      vectors++;
      if (rd0 !== 32'h0 || rd1 !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL zero_bypass got %h/%h exp 0/deadbeef", rd0, rd1);
      end
      vectors++;
      if (nb0 !== 32'h0 || nb1 !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL zero_bypass_nb got %h/%h exp 0/deadbeef", nb0, nb1);
      end
      we = 1'b0;
      tick();
      vectors++;
      if (rd0 !== 32'h0) begin
         fails++;
         $display("FAIL zero_later got %h exp 0", rd0);
      end
      vectors++;
      if (nb0 !== 32'hFFFFFFFF) begin
         fails++;
         $display("FAIL r0_writable_nb got %h exp ffffffff", nb0);
      end
      $display("test_zero_reg done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_read_enable();
      re = 1'b1; raddr = {5'd7, 5'd5};
      tick();
      vectors++;
      if (rd0 !== 32'hDEADBEEF || rd1 !== 32'h12345678) begin
         fails++;
         $display("FAIL re_setup got %h/%h exp deadbeef/12345678", rd0, rd1);
      end
      re = 1'b0; raddr = {5'd3, 5'd3}; we = 1'b1; waddr = 5'd3; wdata = 32'hA5;
      tick();
      we = 1'b0;
      vectors++;
      if (rd0 !== 32'hDEADBEEF || rd1 !== 32'h12345678
          || nb0 !== 32'hDEADBEEF || nb1 !== 32'h12345678) begin
         fails++;
         $display("FAIL re_hold1 got %h/%h %h/%h exp deadbeef/12345678",
                  rd0, rd1, nb0, nb1);
      end
      raddr = {5'd1, 5'd0};
      tick();
      vectors++;
      if (rd0 !== 32'hDEADBEEF || rd1 !== 32'h12345678) begin
         fails++;
         $display("FAIL re_hold2 got %h/%h exp deadbeef/12345678", rd0, rd1);
      end
      re = 1'b1; raddr = {5'd3, 5'd3};
      tick();
      vectors++;
      if (rd0 !== 32'hA5 || rd1 !== 32'hA5 || nb0 !== 32'hA5 || nb1 !== 32'hA5) begin
         fails++;
         $display("FAIL re_resume got %h/%h %h/%h exp a5", rd0, rd1, nb0, nb1);
      end
      re = 1'b0;
      $display("test_read_enable done");
   endtask

   // -----------------------------------------------------------------------
   // Write r1..r31 on consecutive cycles; port 0 reads the entry written the
   // cycle before, port 1 reads the entry being written this cycle.
   task automatic test_back_to_back();
      logic [31:0] exp_prev;
      logic [31:0] exp_prev_nb;
      re = 1'b1;
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'hC0DE0000 | 32'(i);
         raddr = {5'(i), 5'(i - 1)};
         tick();
         exp_prev    = (i == 1) ? 32'h0 : (32'hC0DE0000 | 32'(i - 1));
         exp_prev_nb = (i == 1) ? 32'hFFFFFFFF : (32'hC0DE0000 | 32'(i - 1));
         vectors++;
         if (rd0 !== exp_prev || rd1 !== (32'hC0DE0000 | 32'(i))) begin
            fails++;
            $display("FAIL b2b r%0d got %h/%h exp %h/%h",
                     i, rd0, rd1, exp_prev, 32'hC0DE0000 | 32'(i));
         end
         vectors++;
         if (nb0 !== exp_prev_nb) begin
            fails++;
            $display("FAIL b2b_nb r%0d got %h exp %h", i, nb0, exp_prev_nb);
         end
      end
      we = 1'b0; raddr = {5'd31, 5'd1};
      tick();
      vectors++;
      if (rd0 !== 32'hC0DE0001 || rd1 !== 32'hC0DE001F || nb1 !== 32'hC0DE001F) begin
         fails++;
         $display("FAIL b2b_readback got %h/%h/%h exp c0de0001/c0de001f",
                  rd0, rd1, nb1);
      end
      $display("test_back_to_back done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_clear();
      int  low;
      bit  done;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      low = (ready == 1'b0) ? 1 : 0;
      vectors++;
      if (rdata !== 64'h0 || ready !== 1'b0) begin
         fails++;
         $display("FAIL clear_start got rdy %b rdata %h exp 0/0", ready, rdata);
      end
      for (int i = 1; i < 10; i++) begin
         tick();
         if (ready == 1'b0) low++;
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      if (ready == 1'b0) low++;
      done = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
         tick();
         if (ready == 1'b0) low++;
         else done = 1'b1;
      end
      vectors++;
      if (low != 42) begin
         fails++;
         $display("FAIL clear_low_cycles got %0d exp 42", low);
      end
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         tick();
         vectors++;
         if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
            fails++;
            $display("FAIL clear_read r%0d got %h/%h exp 0", a, rdata, rdata_nb);
         end
      end
      $display("test_clear done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset_mid();
      int  cyc;
      bit  done;
      we = 1'b1; waddr = 5'd4; wdata = 32'h44; re = 1'b0;
      tick();
      we = 1'b0; re = 1'b1; raddr = {5'd4, 5'd4};
      tick();
      vectors++;
      if (rd0 !== 32'h44 || nb1 !== 32'h44) begin
         fails++;
         $display("FAIL mid_setup got %h/%h exp 44", rd0, nb1);
      end
      // reset in the middle of normal operation
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b0 || rdata !== 64'h0 || rdata_nb !== 64'h0) begin
         fails++;
         $display("FAIL op_reset got rdy %b rdata %h/%h exp 0", ready, rdata, rdata_nb);
      end
      tick();
      rst_n = 1'b1; re = 1'b0;
      cyc = 0; done = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
         tick();
         cyc++;
         if (ready == 1'b1) done = 1'b1;
      end
      vectors++;
      if (cyc != 32) begin
         fails++;
         $display("FAIL op_reset_sweep got %0d exp 32", cyc);
      end
      // reset in the middle of a clear sweep
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b0 || rdata !== 64'h0) begin
         fails++;
         $display("FAIL sweep_reset got rdy %b rdata %h exp 0", ready, rdata);
      end
      tick();
      rst_n = 1'b1;
      cyc = 0; done = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
         tick();
         cyc++;
         if (ready == 1'b1) done = 1'b1;
      end
      vectors++;
      if (cyc != 32) begin
         fails++;
         $display("FAIL sweep_reset_sweep got %0d exp 32", cyc);
      end
      re = 1'b1; raddr = {5'd4, 5'd4};
      tick();
      vectors++;
      if (rd0 !== 32'h0 || nb0 !== 32'h0) begin
         fails++;
         $display("FAIL after_reset_r4 got %h/%h exp 0", rd0, nb0);
      end
      $display("test_reset_mid done");
   endtask

   // -----------------------------------------------------------------------
   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_read_enable();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
